// File: rtl/audio_gain_ramp_if.sv
// ============================================================================
// Module   : Axis_If
// Purpose  : Minimal AXI-stream style handshake bundle (data/valid/ready)
//            used for the stereo sample path.
// Ports    : data  - stream word (left channel in upper half, right in lower)
//            valid - producer has a word on data
//            ready - consumer can take the word this cycle
// Modports : Master (drives data/valid), Slave (drives ready)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface Axis_If #(
  parameter int WIDTH = 48
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport Master (output data, output valid, input  ready);
  modport Slave  (input  data, input  valid, output ready);
endinterface

`default_nettype wire

// File: rtl/audio_gain_ramp.sv
// ============================================================================
// Module   : audio_gain_ramp
// Purpose  : Stereo volume stage. Each accepted sample is multiplied by a
//            shared Q2.14 gain that ramps toward the requested target by at
//            most RAMP_STEP per accepted sample, then rounded (half up) and
//            saturated to the sample width. Clipped samples are counted.
// Ports    : clk         - system clock
//            reset       - synchronous, active-high reset
//            s_sample    - input stream  {left, right}, two's complement
//            m_sample    - output stream {left, right}, same packing
//            target_gain - requested gain, Q2.14 unsigned
//            mute        - forces the effective target to zero
//            ramp_busy   - current gain has not yet reached the target
//            clip_count  - saturating count of clipped output samples
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_gain_ramp #(
  parameter int BIT_DEPTH  = 24,
  parameter int GAIN_WIDTH = 16,
  parameter int RAMP_STEP  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  Axis_If.Slave                 s_sample,
  Axis_If.Master                m_sample,
  input  logic [GAIN_WIDTH-1:0] target_gain,
  input  logic                  mute,
  output logic                  ramp_busy,
  output logic [15:0]           clip_count
);

  // Product width: signed sample x (gain zero-extended to a signed operand).
  localparam int PW   = BIT_DEPTH + GAIN_WIDTH + 1;
  // Q2.x format: two integer bits, the rest fractional.
  localparam int FRAC = GAIN_WIDTH - 2;
  // Half an output LSB, added before the arithmetic shift for round-half-up.
  localparam logic signed [PW-1:0]       ROUND = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic [GAIN_WIDTH-1:0]      STEP  = GAIN_WIDTH'(RAMP_STEP);
  localparam logic [15:0]                CNT_MAX = 16'hFFFF;

  logic                   en;
  logic                   acc;
  logic                   w_load;
  logic [GAIN_WIDTH-1:0]  w_tgt;
  logic [GAIN_WIDTH-1:0]  w_dist;
  logic [GAIN_WIDTH-1:0]  gain_q;
  logic [GAIN_WIDTH-1:0]  gain_d;
  logic                   s1_valid_q;
  logic                   m_valid_q;
  logic [2*BIT_DEPTH-1:0] m_data_q;
  logic [15:0]            clip_q;
  logic [2*BIT_DEPTH-1:0] w_sat;
  logic [1:0]             w_clip;

  // Whole pipeline advances together; ready depends only on output state.
  assign en             = !m_valid_q || m_sample.ready;
  assign s_sample.ready = en;
  assign acc            = s_sample.valid && en;
  assign w_load         = en && s1_valid_q;

  assign w_tgt     = mute ? '0 : target_gain;
  assign ramp_busy = (gain_q != w_tgt);

  // Gain only moves on accepted samples, so an idle stream freezes the ramp.
  always_comb begin
    gain_d = gain_q;
    w_dist = (gain_q < w_tgt) ? (w_tgt - gain_q) : (gain_q - w_tgt);
    if (acc) begin
      if (w_dist <= STEP) begin
        gain_d = w_tgt;
      end else if (gain_q < w_tgt) begin
        gain_d = gain_q + STEP;
      end else begin
        gain_d = gain_q - STEP;
      end
    end
  end

  // Per-channel multiply (S1) and round/saturate (feeds S2).
  // Channel 0 is the right sample (low half), channel 1 the left.
  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic signed [BIT_DEPTH-1:0] w_smp;
    logic signed [PW-1:0]        prod_q;
    logic signed [PW-1:0]        w_shift;
    logic                        w_ovf;

    assign w_smp = s_sample.data[ch*BIT_DEPTH +: BIT_DEPTH];

    // The gain used is the pre-update value of the acceptance cycle.
    always_ff @(posedge clk) begin
      if (acc) begin
        prod_q <= w_smp * $signed({1'b0, gain_q});
      end
    end

    assign w_shift = (prod_q + ROUND) >>> FRAC;

    // Result fits only if every bit above the output sign bit matches it.
    assign w_ovf = (w_shift[PW-1:BIT_DEPTH-1] != {(PW-BIT_DEPTH+1){w_shift[PW-1]}});

    assign w_clip[ch] = w_ovf;
    assign w_sat[ch*BIT_DEPTH +: BIT_DEPTH] =
        !w_ovf        ? w_shift[BIT_DEPTH-1:0] :
        w_shift[PW-1] ? {1'b1, {(BIT_DEPTH-1){1'b0}}} :
                        {1'b0, {(BIT_DEPTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gain_q     <= '0;
      s1_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      clip_q     <= '0;
    end else begin
      gain_q <= gain_d;
      if (en) begin
        s1_valid_q <= s_sample.valid;
        m_valid_q  <= s1_valid_q;
      end
      // One count per clipped sample, regardless of how many channels clipped.
      if (w_load && (|w_clip) && (clip_q != CNT_MAX)) begin
        clip_q <= clip_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      m_data_q <= w_sat;
    end
  end

  assign m_sample.valid = m_valid_q;
  assign m_sample.data  = m_data_q;
  assign clip_count     = clip_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_gain_ramp.sv
// ============================================================================
// Module   : tb_audio_gain_ramp
// Purpose  : Directed self-checking bench for audio_gain_ramp: reset state,
//            fade-in ramp, unity pass-through latency, saturation, rounding,
//            backpressure ordering, mute ramp and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_gain_ramp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] target_gain;
  logic        mute;
  logic        ramp_busy;
  logic [15:0] clip_count;

  Axis_If #(.WIDTH(48)) s_if ();
  Axis_If #(.WIDTH(48)) m_if ();

  audio_gain_ramp #(
    .BIT_DEPTH (24),
    .GAIN_WIDTH(16),
    .RAMP_STEP (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_sample   (s_if),
    .m_sample   (m_if),
    .target_gain(target_gain),
    .mute       (mute),
    .ramp_busy  (ramp_busy),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output ready pattern: 0 = always ready, 1 = random, 2 = stalled.
  int rdy_mode = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      0:       m_if.ready = 1'b1;
      1:       m_if.ready = 1'($urandom_range(0, 1));
      default: m_if.ready = 1'b0;
    endcase
  end

  // Output collector plus stall-behaviour observers.
  logic [47:0] out_q[$];
  int          stall_leak = 0;
  int          hold_err   = 0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_data  = '0;

  always @(posedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (m_if.valid && m_if.ready) out_q.push_back(m_if.data);
      if (m_if.valid && !m_if.ready && s_if.ready) stall_leak <= stall_leak + 1;
      if (prev_stall && (!m_if.valid || m_if.data !== prev_data)) hold_err <= hold_err + 1;
      prev_stall <= m_if.valid && !m_if.ready;
      prev_data  <= m_if.data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Offer one word; returns just after the edge on which it was accepted.
  task automatic push(input logic [47:0] d);
    int t;
    t = 0;
    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = d;
    #1;
    while (!s_if.ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL push_timeout: s_ready stuck low for %0d cycles, required accept within 200", t);
    end
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    int t;
    t = 0;
    while (out_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (out_q.size() >= n);
  endtask

  // Ramp to a new target with zero-valued samples and flush the pipeline.
  task automatic settle(input logic [15:0] g);
    int n;
    @(negedge clk);
    target_gain = g;
    n = 0;
    #1;
    while (ramp_busy && n < 3000) begin
      push(48'h0);
      n++;
    end
    checks++;
    if (ramp_busy) begin
      errors++;
      $display("FAIL settle_%h: ramp_busy still %b after %0d samples, required 0", g, ramp_busy, n);
    end
    repeat (4) @(negedge clk);
    out_q.delete();
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    mute        = 1'b0;
    target_gain = 16'h0000;
    s_if.valid  = 1'b0;
    s_if.data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (m_if.valid !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid: got %b, required 0", m_if.valid);
    end
    checks++;
    if (clip_count !== 16'h0000) begin
      errors++; $display("FAIL reset_clip_count: got %h, required 0000", clip_count);
    end
    checks++;
    if (ramp_busy !== 1'b0) begin
      errors++; $display("FAIL reset_ramp_busy_tgt0: got %b, required 0", ramp_busy);
    end
    checks++;
    if (s_if.ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: got %b, required 1", s_if.ready);
    end
    @(negedge clk);
    target_gain = 16'h4000;
    #1;
    checks++;
    if (ramp_busy !== 1'b1) begin
      errors++; $display("FAIL reset_ramp_busy_tgt4000: got %b, required 1", ramp_busy);
    end
  endtask

  // Gain for sample k is 16*k, so output k is 0x100000*16k/16384 = 1024*k.
  task automatic test_fade_in;
    bit          ok;
    logic [23:0] e;
    out_q.delete();
    for (int k = 0; k < 1100; k++) begin
      push(48'h100000_100000);
      if (k == 1022) begin
        checks++;
        if (ramp_busy !== 1'b1) begin
          errors++; $display("FAIL fade_busy_1023: got %b, required 1", ramp_busy);
        end
      end
      if (k == 1023) begin
        checks++;
        if (ramp_busy !== 1'b0) begin
          errors++; $display("FAIL fade_busy_1024: got %b, required 0", ramp_busy);
        end
      end
    end
    wait_out(1100, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL fade_count: got %0d outputs, required 1100", out_q.size());
    end else begin
      for (int k = 0; k < 1100; k++) begin
        e = (k < 1024) ? 24'(k * 1024) : 24'h100000;
        checks++;
        if (out_q[k] !== {e, e}) begin
          errors++; $display("FAIL fade_out[%0d]: got %h, required %h", k, out_q[k], {e, e});
        end
      end
    end
    repeat (4) @(negedge clk);
    out_q.delete();
  endtask

  task automatic test_unity_latency;
    repeat (4) @(negedge clk);
    out_q.delete();
    push({24'h123456, 24'hEDCBAA});
    checks++;
    if (m_if.valid !== 1'b0) begin
      errors++; $display("FAIL unity_valid_early: got %b one cycle after accept, required 0", m_if.valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_if.valid !== 1'b1 || m_if.data !== {24'h123456, 24'hEDCBAA}) begin
      errors++; $display("FAIL unity_out: got valid=%b data=%h, required valid=1 data=123456edcbaa",
                         m_if.valid, m_if.data);
    end
    checks++;
    if (clip_count !== 16'h0000) begin
      errors++; $display("FAIL unity_clip_count: got %h, required 0000", clip_count);
    end
    repeat (3) @(negedge clk);
    out_q.delete();
  endtask

  task automatic test_saturation;
    bit ok;
    settle(16'h8000);
    push({24'h500000, 24'hA00000});
    wait_out(1, ok);
    checks++;
    if (!ok || out_q[0] !== {24'h7FFFFF, 24'h800000}) begin
      errors++; $display("FAIL sat_out: got %h (n=%0d), required 7fffff800000", ok ? out_q[0] : 48'h0, out_q.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (clip_count !== 16'h0001) begin
      errors++; $display("FAIL sat_clip_count: got %h, required 0001", clip_count);
    end
    out_q.delete();
  endtask

  task automatic test_rounding;
    bit ok;
    settle(16'h2000);
    push({24'h000003, 24'hFFFFFD});
    wait_out(1, ok);
    checks++;
    if (!ok || out_q[0] !== {24'h000002, 24'hFFFFFF}) begin
      errors++; $display("FAIL round_out: got %h (n=%0d), required 000002ffffff", ok ? out_q[0] : 48'h0, out_q.size());
    end
    checks++;
    if (clip_count !== 16'h0001) begin
      errors++; $display("FAIL round_clip_count: got %h, required 0001", clip_count);
    end
    out_q.delete();
  endtask

  // Counting pattern at unity gain with a hard stall and random backpressure.
  task automatic test_back_to_back;
    bit          ok;
    logic [23:0] l;
    logic [23:0] r;
    settle(16'h4000);
    stall_leak = 0;
    hold_err   = 0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          l = 24'(i + 1);
          r = 24'(-(i + 1));
          push({l, r});
        end
      end
      begin
        repeat (20) @(negedge clk);
        rdy_mode = 2;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (s_if.ready !== 1'b0 || m_if.valid !== 1'b1) begin
          errors++; $display("FAIL b2b_stall: got s_ready=%b m_valid=%b, required 0/1", s_if.ready, m_if.valid);
        end
        repeat (5) @(negedge clk);
        rdy_mode = 1;
      end
    join
    rdy_mode = 0;
    wait_out(80, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, required 80", out_q.size());
    end else begin
      for (int i = 0; i < 80; i++) begin
        l = 24'(i + 1);
        r = 24'(-(i + 1));
        checks++;
        if (out_q[i] !== {l, r}) begin
          errors++; $display("FAIL b2b_out[%0d]: got %h, required %h", i, out_q[i], {l, r});
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_q.size() != 80) begin
      errors++; $display("FAIL b2b_extra: got %0d outputs, required 80", out_q.size());
    end
    checks++;
    if (stall_leak != 0) begin
      errors++; $display("FAIL b2b_ready_leak: got %0d stalled cycles with s_ready=1, required 0", stall_leak);
    end
    checks++;
    if (hold_err != 0) begin
      errors++; $display("FAIL b2b_hold: got %0d unstable stalled outputs, required 0", hold_err);
    end
    out_q.delete();
  endtask

  // Gain for sample k is 0x4000-16k, so output k is 1024*(1024-k).
  task automatic test_mute;
    bit          ok;
    logic [23:0] e;
    @(negedge clk);
    mute = 1'b1;
    #1;
    checks++;
    if (ramp_busy !== 1'b1) begin
      errors++; $display("FAIL mute_busy_start: got %b, required 1", ramp_busy);
    end
    for (int k = 0; k < 1024; k++) begin
      push(48'h100000_100000);
      if (k == 1022) begin
        checks++;
        if (ramp_busy !== 1'b1) begin
          errors++; $display("FAIL mute_busy_1023: got %b, required 1", ramp_busy);
        end
      end
    end
    checks++;
    if (ramp_busy !== 1'b0) begin
      errors++; $display("FAIL mute_busy_end: got %b, required 0", ramp_busy);
    end
    wait_out(1024, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mute_count: got %0d outputs, required 1024", out_q.size());
    end else begin
      for (int k = 0; k < 1024; k++) begin
        e = 24'((1024 - k) * 1024);
        checks++;
        if (out_q[k] !== {e, e}) begin
          errors++; $display("FAIL mute_out[%0d]: got %h, required %h", k, out_q[k], {e, e});
        end
      end
    end
    repeat (4) @(negedge clk);
    out_q.delete();
  endtask

  task automatic test_reset_midstream;
    bit ok;
    @(negedge clk);
    mute       = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 48'h100000_100000;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_if.valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid: got %b, required 0", m_if.valid);
    end
    checks++;
    if (clip_count !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_clip_count: got %h, required 0000", clip_count);
    end
    @(negedge clk);
    reset      = 1'b0;
    s_if.valid = 1'b0;
    out_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (m_if.valid !== 1'b0 || out_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_flush: got valid=%b outputs=%0d, required 0/0", m_if.valid, out_q.size());
    end
    checks++;
    if (ramp_busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy: got %b, required 1", ramp_busy);
    end
    push(48'h100000_100000);
    push(48'h100000_100000);
    wait_out(2, ok);
    checks++;
    if (!ok || out_q[0] !== 48'h0 || out_q[1] !== 48'h000400_000400) begin
      errors++; $display("FAIL rst_mid_gain0: got n=%0d first=%h second=%h, required 000000000000 000400000400",
                         out_q.size(), ok ? out_q[0] : 48'h0, ok ? out_q[1] : 48'h0);
    end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_unity_latency();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_mute();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
